vrf_writeback: RTL and testbench
================================

VRF_WRITEBACK -- requirements
Module: vrf_writeback

Interface
REQ-001: clk  in  1  single clock; all state updates on rising edge.
REQ-002: reset  in  1  synchronous, active-high reset.
REQ-003: wb_valid_in  in  1  ALU result present this cycle.
REQ-004: ALU_out  in  [0:63]  ALU result; bit 0 = MSB, byte k = bits 8k:8k+7.
REQ-005: wb_wrEn_in  in  1  instruction writes a register.
REQ-006: wb_rD_in  in  [0:4]  destination register index.
REQ-007: wb_ppp_in  in  [0:2]  participation field selecting written bytes.
REQ-008: stall_in  in  1  freeze writeback stage.
REQ-009: rA_addr, rB_addr  in  [0:4] each  read addresses.
REQ-010: rA_64bit_val, rB_64bit_val  out  [0:63] each  operands to ALU.
REQ-011: wb_busy  out  1  held writeback entry is valid.

Function
REQ-012: Storage SHALL be 32 x 64-bit registers; R0 SHALL read 0 and ignore writes.
REQ-013: A one-entry pipeline register SHALL hold {valid, wrEn, rD, ppp, data}; wb_busy = held valid.
REQ-014: On an edge with stall_in=0, the held entry SHALL commit if valid, wrEn=1 and rD!=0. The register SHALL then load the current inputs, with valid = wb_valid_in.
REQ-015: On an edge with stall_in=1, the pipeline register and register file SHALL be unchanged; inputs SHALL be dropped and upstream holds them.
REQ-016: Each held entry SHALL commit exactly once. Latency is 2 edges from input to register-file update when unstalled.
REQ-017: PPP byte masks on commit, bytes 0..7:
- 000: all.
- 001: 0-3 (bits 0:31).
- 010: 4-7 (bits 32:63).
- 011: even bytes 0,2,4,6.
- 100: odd bytes 1,3,5,7.
- 101-111: none.
Unselected bytes SHALL keep their old value.
REQ-018: Reads SHALL be combinational from addresses.
REQ-019: Read bypass: if the held entry is valid, wrEn=1, rD!=0 and rD equals the read address, the output SHALL be old register bytes merged with held data bytes per the PPP mask. This SHALL apply whether stalled or not.
REQ-020: Both read ports SHALL be independent; the same address on both ports SHALL give identical values.
REQ-021: Reads of R0 SHALL return 0 regardless of bypass.
REQ-022: Back-to-back writes to the same rD SHALL commit in order; the later entry overlays the earlier per its own mask.
REQ-023: wb_valid_in=0 SHALL load a bubble; a bubble commits nothing.

Reset
REQ-024: reset=1 at an edge SHALL clear the held entry (valid=0) and zero all 32 registers; reset SHALL take priority over stall_in.
REQ-025: A held entry pending at reset SHALL be discarded, not committed.
REQ-026: During and after reset, wb_busy=0 and both read outputs SHALL be 0 until the first commit.

Verification
REQ-027: Reset, then read R5 on both ports -> rA_64bit_val = rB_64bit_val = 64'h0, wb_busy=0.
REQ-028: Write rD=3, ppp=000, ALU_out=64'hFFFFFFFF_00000000, no stall -> after the 2nd edge, reading R3 gives FFFFFFFF_00000000. One cycle after capture, reading R3 via bypass also gives FFFFFFFF_00000000.
REQ-029: With R3 holding 64'h1111111122222222, perform three writes with ALU_out=64'hAAAAAAAAAAAAAAAA:
- ppp=001 -> AAAAAAAA22222222.
- then ppp=100 on the fresh R3=1111111122222222 -> 11AA11AA22AA22AA.
- ppp=110 -> unchanged.
REQ-030: Write rD=0, ppp=000, data=64'hDEADBEEF_DEADBEEF -> R0 reads 0 on both ports; no bypass.
REQ-031: Hold stall_in=1 for 3 cycles with an entry (rD=7, data=64'd15) held -> R7 reads 15 via bypass, register file unchanged, wb_busy=1. Release stall -> commit on the next edge; new input captured the same edge.
REQ-032: Assert reset while an entry (rD=9, data=64'd5) is held -> R9 reads 0 after reset, wb_busy=0.

Source files
------------

// File: rtl/vrf_writeback.sv
// Writeback stage plus 32 x 64-bit register file with a one-entry held result,
// byte-granular partial writes (PPP field) and a merged read bypass.
module vrf_writeback (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid_in,
  input  logic [63:0] ALU_out,
  input  logic        wb_wrEn_in,
  input  logic [4:0]  wb_rD_in,
  input  logic [2:0]  wb_ppp_in,
  input  logic        stall_in,
  input  logic [4:0]  rA_addr,
  input  logic [4:0]  rB_addr,
  output logic [63:0] rA_64bit_val,
  output logic [63:0] rB_64bit_val,
  output logic        wb_busy
);

  // Vectors use [63:0]; the architectural "bit 0" MSB is bit 63 here, so byte k
  // lives at [63-8k -: 8] and hex values read identically.
  function automatic logic [63:0] pppMask(input logic [2:0] ppp);
    case (ppp)
      3'b000:  pppMask = 64'hFFFF_FFFF_FFFF_FFFF;
      3'b001:  pppMask = 64'hFFFF_FFFF_0000_0000;
      3'b010:  pppMask = 64'h0000_0000_FFFF_FFFF;
      3'b011:  pppMask = 64'hFF00_FF00_FF00_FF00;
      3'b100:  pppMask = 64'h00FF_00FF_00FF_00FF;
      default: pppMask = 64'h0000_0000_0000_0000;
    endcase
  endfunction

  logic [63:0] rf_q [32];

  logic        heldValid_q, heldValid_d;
  logic        heldWrEn_q,  heldWrEn_d;
  logic [4:0]  heldRd_q,    heldRd_d;
  logic [2:0]  heldPpp_q,   heldPpp_d;
  logic [63:0] heldData_q,  heldData_d;

  logic        heldWrites;
  logic [63:0] heldMask;
  logic [63:0] commitData;

  // The merged value serves both the commit and the bypass, so a read of the
  // held destination always sees exactly what the commit will store.
  assign heldWrites = heldValid_q & heldWrEn_q & (heldRd_q != 5'd0);
  assign heldMask   = pppMask(heldPpp_q);
  assign commitData = (rf_q[heldRd_q] & ~heldMask) | (heldData_q & heldMask);
  assign wb_busy    = heldValid_q;

  assign rA_64bit_val = (rA_addr == 5'd0) ? 64'd0 :
                        (heldWrites && (heldRd_q == rA_addr)) ? commitData : rf_q[rA_addr];
  assign rB_64bit_val = (rB_addr == 5'd0) ? 64'd0 :
                        (heldWrites && (heldRd_q == rB_addr)) ? commitData : rf_q[rB_addr];

  always_comb begin
    heldValid_d = heldValid_q;
    heldWrEn_d  = heldWrEn_q;
    heldRd_d    = heldRd_q;
    heldPpp_d   = heldPpp_q;
    heldData_d  = heldData_q;
    if (!stall_in) begin
      heldValid_d = wb_valid_in;
      heldWrEn_d  = wb_wrEn_in;
      heldRd_d    = wb_rD_in;
      heldPpp_d   = wb_ppp_in;
      heldData_d  = ALU_out;
    end
  end

  // Reset discards any pending entry instead of committing it.
  always_ff @(posedge clk) begin
    if (reset) begin
      heldValid_q <= 1'b0;
      heldWrEn_q  <= 1'b0;
      heldRd_q    <= 5'd0;
      heldPpp_q   <= 3'd0;
      heldData_q  <= 64'd0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 64'd0;
    end else begin
      heldValid_q <= heldValid_d;
      heldWrEn_q  <= heldWrEn_d;
      heldRd_q    <= heldRd_d;
      heldPpp_q   <= heldPpp_d;
      heldData_q  <= heldData_d;
      if (!stall_in && heldWrites) rf_q[heldRd_q] <= commitData;
    end
  end

endmodule

// File: tb/tb_vrf_writeback.sv
// Directed self-checking bench for vrf_writeback: reset, PPP masks, bypass,
// R0 handling, stall, back-to-back writes and reset with a pending entry.
module tb_vrf_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid_in;
  logic [63:0] ALU_out;
  logic        wb_wrEn_in;
  logic [4:0]  wb_rD_in;
  logic [2:0]  wb_ppp_in;
  logic        stall_in;
  logic [4:0]  rA_addr;
  logic [4:0]  rB_addr;
  logic [63:0] rA_64bit_val;
  logic [63:0] rB_64bit_val;
  logic        wb_busy;

  int checks   = 0;
  int failures = 0;

  vrf_writeback dut (
    .clk          (clk),
    .reset        (reset),
    .wb_valid_in  (wb_valid_in),
    .ALU_out      (ALU_out),
    .wb_wrEn_in   (wb_wrEn_in),
    .wb_rD_in     (wb_rD_in),
    .wb_ppp_in    (wb_ppp_in),
    .stall_in     (stall_in),
    .rA_addr      (rA_addr),
    .rB_addr      (rB_addr),
    .rA_64bit_val (rA_64bit_val),
    .rB_64bit_val (rB_64bit_val),
    .wb_busy      (wb_busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic we, input logic [4:0] rd,
                               input logic [2:0] ppp, input logic [63:0] data);
    wb_valid_in = v;
    wb_wrEn_in  = we;
    wb_rD_in    = rd;
    wb_ppp_in   = ppp;
    ALU_out     = data;
  endtask

  // Capture on one edge, commit on the next with a bubble behind it.
  task automatic doWrite(input logic [4:0] rd, input logic [2:0] ppp, input logic [63:0] data);
    applyStimulus(1'b1, 1'b1, rd, ppp, data);
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 3'd0, 64'd0);
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stall_in = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd0, 3'd0, 64'd0);
    rA_addr = 5'd5;
    rB_addr = 5'd5;
    step();
    step();
    checks++;
    if (rA_64bit_val !== 64'd0 || rB_64bit_val !== 64'd0 || wb_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_during rA=%h rB=%h busy=%b expected 0/0/0", rA_64bit_val, rB_64bit_val, wb_busy);
    end
    reset = 1'b0;
    step();
    checks++;
    if (rA_64bit_val !== 64'd0 || rB_64bit_val !== 64'd0 || wb_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_after rA=%h rB=%h busy=%b expected 0/0/0", rA_64bit_val, rB_64bit_val, wb_busy);
    end
  endtask

  task automatic test_basic_write();
    rA_addr = 5'd3;
    rB_addr = 5'd3;
    applyStimulus(1'b1, 1'b1, 5'd3, 3'b000, 64'hFFFFFFFF_00000000);
    step();
    checks++;
    if (rA_64bit_val !== 64'hFFFFFFFF_00000000 || wb_busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_bypass rA=%h busy=%b expected FFFFFFFF00000000/1", rA_64bit_val, wb_busy);
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 3'd0, 64'd0);
    step();
    checks++;
    if (rA_64bit_val !== 64'hFFFFFFFF_00000000 || rB_64bit_val !== 64'hFFFFFFFF_00000000 || wb_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_commit rA=%h rB=%h busy=%b expected FFFFFFFF00000000 x2/0", rA_64bit_val, rB_64bit_val, wb_busy);
    end
  endtask

  task automatic test_ppp();
    logic [2:0]  pppVec [6];
    logic [63:0] expVec [6];
    pppVec = '{3'b001, 3'b100, 3'b110, 3'b010, 3'b011, 3'b101};
    expVec = '{64'hAAAAAAAA_22222222, 64'h11AA11AA_22AA22AA, 64'h11111111_22222222,
               64'h11111111_AAAAAAAA, 64'hAA11AA11_AA22AA22, 64'h11111111_22222222};
    rA_addr = 5'd3;
    rB_addr = 5'd3;
    for (int i = 0; i < 6; i++) begin
      doWrite(5'd3, 3'b000, 64'h11111111_22222222);
      applyStimulus(1'b1, 1'b1, 5'd3, pppVec[i], 64'hAAAAAAAA_AAAAAAAA);
      step();
      checks++;
      if (rB_64bit_val !== expVec[i]) begin
        failures++;
        $display("[TB] FAIL ppp_bypass ppp=%b got=%h expected=%h", pppVec[i], rB_64bit_val, expVec[i]);
      end
      applyStimulus(1'b0, 1'b0, 5'd0, 3'd0, 64'd0);
      step();
      checks++;
      if (rA_64bit_val !== expVec[i]) begin
        failures++;
        $display("[TB] FAIL ppp_commit ppp=%b got=%h expected=%h", pppVec[i], rA_64bit_val, expVec[i]);
      end
    end
  endtask

  task automatic test_r0();
    rA_addr = 5'd0;
    rB_addr = 5'd0;
    applyStimulus(1'b1, 1'b1, 5'd0, 3'b000, 64'hDEADBEEF_DEADBEEF);
    step();
    checks++;
    if (rA_64bit_val !== 64'd0 || rB_64bit_val !== 64'd0 || wb_busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL r0_held rA=%h rB=%h busy=%b expected 0/0/1", rA_64bit_val, rB_64bit_val, wb_busy);
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 3'd0, 64'd0);
    step();
    checks++;
    if (rA_64bit_val !== 64'd0 || rB_64bit_val !== 64'd0) begin
      failures++;
      $display("[TB] FAIL r0_after rA=%h rB=%h expected 0/0", rA_64bit_val, rB_64bit_val);
    end
  endtask

  task automatic test_stall();
    rA_addr = 5'd7;
    rB_addr = 5'd8;
    applyStimulus(1'b1, 1'b1, 5'd7, 3'b000, 64'd15);
    step();
    stall_in = 1'b1;
    applyStimulus(1'b1, 1'b1, 5'd8, 3'b000, 64'h42);
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (rA_64bit_val !== 64'd15 || rB_64bit_val !== 64'd0 || wb_busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL stall_hold cyc=%0d r7=%h r8=%h busy=%b expected 15/0/1", c, rA_64bit_val, rB_64bit_val, wb_busy);
      end
    end
    stall_in = 1'b0;
    step();
    checks++;
    if (rA_64bit_val !== 64'd15 || rB_64bit_val !== 64'h42 || wb_busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stall_release r7=%h r8=%h busy=%b expected 15/42/1", rA_64bit_val, rB_64bit_val, wb_busy);
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 3'd0, 64'd0);
    step();
    checks++;
    if (rA_64bit_val !== 64'd15 || rB_64bit_val !== 64'h42 || wb_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_drain r7=%h r8=%h busy=%b expected 15/42/0", rA_64bit_val, rB_64bit_val, wb_busy);
    end
  endtask

  task automatic test_back_to_back();
    rA_addr = 5'd10;
    rB_addr = 5'd10;
    applyStimulus(1'b1, 1'b1, 5'd10, 3'b000, 64'h01020304_05060708);
    step();
    applyStimulus(1'b1, 1'b1, 5'd10, 3'b001, 64'hFFFFFFFF_FFFFFFFF);
    step();
    checks++;
    if (rA_64bit_val !== 64'hFFFFFFFF_05060708) begin
      failures++;
      $display("[TB] FAIL b2b_bypass got=%h expected=FFFFFFFF05060708", rA_64bit_val);
    end
    applyStimulus(1'b1, 1'b0, 5'd10, 3'b000, 64'd0);
    step();
    checks++;
    if (rB_64bit_val !== 64'hFFFFFFFF_05060708 || wb_busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_nowren got=%h busy=%b expected FFFFFFFF05060708/1", rB_64bit_val, wb_busy);
    end
    applyStimulus(1'b0, 1'b1, 5'd10, 3'b000, 64'd0);
    step();
    step();
    checks++;
    if (rA_64bit_val !== 64'hFFFFFFFF_05060708 || wb_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_bubble got=%h busy=%b expected FFFFFFFF05060708/0", rA_64bit_val, wb_busy);
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 3'd0, 64'd0);
  endtask

  task automatic test_reset_pending();
    rA_addr = 5'd9;
    rB_addr = 5'd3;
    applyStimulus(1'b1, 1'b1, 5'd9, 3'b000, 64'd5);
    step();
    checks++;
    if (rA_64bit_val !== 64'd5 || wb_busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rstpend_held r9=%h busy=%b expected 5/1", rA_64bit_val, wb_busy);
    end
    reset = 1'b1;
    stall_in = 1'b1;
    step();
    reset = 1'b0;
    stall_in = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd0, 3'd0, 64'd0);
    checks++;
    if (rA_64bit_val !== 64'd0 || rB_64bit_val !== 64'd0 || wb_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstpend_reset r9=%h r3=%h busy=%b expected 0/0/0", rA_64bit_val, rB_64bit_val, wb_busy);
    end
    step();
    checks++;
    if (rA_64bit_val !== 64'd0 || wb_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstpend_after r9=%h busy=%b expected 0/0", rA_64bit_val, wb_busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_ppp();
    test_r0();
    test_stall();
    test_back_to_back();
    test_reset_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
